icache_line: RTL and testbench

Parametrised direct-mapped instruction cache with multi-word lines, between the instruction fetch unit and the memory controller. Serves registered hits in one cycle. On a miss, refills the whole line word-by-word over the existing single-word memory-controller handshake. Supports a global invalidate for fence.i and self-modifying-code flushes.

---
 rtl/icache_line_pkg.sv | 19 +
 rtl/icache_data_array.sv | 63 ++++++
 rtl/icache_line.sv | 167 ++++++++++++++++
 tb/tb_icache_line.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_line_pkg.sv
// rtl/icache_line_pkg.sv - shared FSM encodings and address-split helpers for icache_line
package icache_line_pkg;

  // Refill controller states
  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_FILL = 1'b1
  } icache_state_t;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BYTE_OFF_W = 2;

  // Number of word-select bits inside a line (0 for single-word lines)
  function automatic int word_bits(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 0;
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// rtl/icache_data_array.sv - line data RAM with tag and valid arrays, async read, sync write
module icache_data_array
  import icache_line_pkg::*;
#(
  parameter int LINES      = 128,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 7,
  parameter int WORD_W     = 2,
  parameter int TAG_W      = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WORD_W-1:0] rd_word,
  output logic [DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              data_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              tag_we,
  input  logic              valid_set,
  input  logic              valid_kill,
  input  logic              clear_all
);

  logic [DATA_W-1:0] data_mem [LINES][LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_q;

  assign rd_data  = data_mem[rd_idx][rd_word];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid_q[rd_idx];

  // Refill word write into the line being filled
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[wr_idx][wr_word] <= wr_data;
    end
  end

  // Tag is captured once the last word of the line lands
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[wr_idx] <= wr_tag;
    end
  end

  // Valid bits: global clear wins over per-line kill/set
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else begin
      if (valid_kill) valid_q[wr_idx] <= 1'b0;
      if (valid_set)  valid_q[wr_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/icache_line.sv
// rtl/icache_line.sv - direct-mapped multi-word-line icache; ICACHE_PERF_EN adds hit/miss counters
module icache_line
  import icache_line_pkg::*;
#(
  parameter int LINES      = 128,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_enable,
  input  logic [31:0] pc,
  input  logic        invalidate,
  output logic        hit,
  output logic [31:0] hit_data,
  output logic        mem_enable,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst,
  input  logic        mem_valid
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);

  localparam int WORD_BITS = word_bits(LINE_WORDS);
  localparam int WORD_W    = (WORD_BITS > 0) ? WORD_BITS : 1;
  localparam int OFF_W     = WORD_BITS + BYTE_OFF_W;
  localparam int IDX_W     = $clog2(LINES);
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W    = ADDR_W - OFF_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  icache_state_t     state;
  logic [LINE_W-1:0] line_q;
  logic [WORD_W-1:0] cnt;
  logic              inval_seen;

  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [WORD_W-1:0] pc_word;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic [DATA_W-1:0] rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              hit_now;
  logic              start_fill;
  logic              beat;
  logic              last_beat;
  logic [WORD_W-1:0] cnt_next;
  logic [ADDR_W-1:0] next_addr;
  logic [IDX_W-1:0]  wr_idx;
  logic              unused_pc_bits;

  assign pc_idx = pc[OFF_W +: IDX_W];
  assign pc_tag = pc[ADDR_W-1 -: TAG_W];
  assign unused_pc_bits = ^pc[BYTE_OFF_W-1:0];

  if (WORD_BITS > 0) begin : g_word_sel
    assign pc_word = pc[OFF_W-1:BYTE_OFF_W];
  end else begin : g_single_word
    assign pc_word = '0;
  end

  assign fill_idx = line_q[IDX_W-1:0];
  assign fill_tag = line_q[LINE_W-1:IDX_W];

  assign hit_now    = fetch_enable && rd_valid && (rd_tag == pc_tag);
  assign start_fill = rdy && (state == ICACHE_IDLE) && fetch_enable && !hit_now;
  assign beat       = rdy && (state == ICACHE_FILL) && mem_valid;
  assign last_beat  = beat && (cnt == LAST_WORD);

  // Word counter wraps inside the line so the address never leaves it
  assign cnt_next  = (cnt == LAST_WORD) ? '0 : cnt + WORD_W'(1);
  assign next_addr = {line_q, {OFF_W{1'b0}}} | (ADDR_W'(cnt_next) << BYTE_OFF_W);

  // Writes target the line under refill; in IDLE the index of a new miss
  assign wr_idx = (state == ICACHE_FILL) ? fill_idx : pc_idx;

  icache_data_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W),
    .WORD_W     (WORD_W),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (pc_idx),
    .rd_word    (pc_word),
    .rd_data    (rd_data),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .wr_idx     (wr_idx),
    .wr_word    (cnt),
    .wr_data    (inst),
    .data_we    (beat),
    .wr_tag     (fill_tag),
    .tag_we     (last_beat),
    .valid_set  (last_beat && !inval_seen && !invalidate),
    .valid_kill (start_fill),
    .clear_all  (rdy && invalidate)
  );

  // Refill controller: latch the missing line, stream its words in, then publish the tag
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ICACHE_IDLE;
      line_q     <= '0;
      cnt        <= '0;
      inval_seen <= 1'b0;
      mem_enable <= 1'b0;
      inst_addr  <= '0;
    end else if (rdy) begin
      case (state)
        ICACHE_IDLE: begin
          if (fetch_enable && !hit_now) begin
            state      <= ICACHE_FILL;
            line_q     <= pc[ADDR_W-1:OFF_W];
            cnt        <= '0;
            inval_seen <= 1'b0;
            mem_enable <= 1'b1;
            inst_addr  <= {pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
        ICACHE_FILL: begin
          if (invalidate) inval_seen <= 1'b1;
          if (mem_valid) begin
            cnt       <= cnt_next;
            inst_addr <= next_addr;
            if (cnt == LAST_WORD) begin
              mem_enable <= 1'b0;
              state      <= ICACHE_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Registered hit response; data holds its last value on a miss
  always_ff @(posedge clk) begin
    if (rst) begin
      hit      <= 1'b0;
      hit_data <= '0;
    end else if (rdy) begin
      hit <= hit_now;
      if (hit_now) hit_data <= rd_data;
    end
  end

`ifdef ICACHE_PERF_EN
  // Free-running hit/miss counters, frozen with the rest of the cache
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (rdy) begin
      if (hit_now)    perf_hits   <= perf_hits + 32'd1;
      if (start_fill) perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_line.sv
// tb/tb_icache_line.sv - scoreboard bench for icache_line (LINES=128, LINE_WORDS=4)
module tb_icache_line;

  logic        clk = 1'b0;
  logic        rst, rdy, fetch_enable, invalidate, mem_valid;
  logic [31:0] pc, inst, hit_data, inst_addr;
  logic        hit, mem_enable;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hits, perf_misses;
  logic [31:0] ph0, pm0;
`endif

  int vecs = 0;
  int errs = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_hit_q[$];
  bit   auto_resp = 1'b0;
  bit   gappy = 1'b0;
  bit   gap_phase = 1'b0;
  logic rdy_prev = 1'b1;

  always #5 clk = ~clk;

  icache_line #(.LINES(128), .LINE_WORDS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .fetch_enable (fetch_enable),
    .pc           (pc),
    .invalidate   (invalidate),
    .hit          (hit),
    .hit_data     (hit_data),
    .mem_enable   (mem_enable),
    .inst_addr    (inst_addr),
    .inst         (inst),
    .mem_valid    (mem_valid)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hits    (perf_hits),
    .perf_misses  (perf_misses)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory controller model: answers the current request, optionally every other cycle
  always @(posedge clk) begin
    #1;
    if (auto_resp) begin
      mem_valid = mem_enable && !(gappy && gap_phase);
      gap_phase = ~gap_phase;
      inst      = mem_word(inst_addr);
    end
  end

  always @(posedge clk) rdy_prev <= rdy;

  // Monitor: every accepted memory request and every hit is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst && rdy && mem_enable && mem_valid) begin
      if (exp_addr_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL unexpected_request: got %h expected none", inst_addr);
      end else begin
        check("request_addr", inst_addr, exp_addr_q.pop_front());
      end
    end
    if (!rst && rdy_prev && hit) begin
      if (exp_hit_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL spurious_hit: got hit data %h expected no hit", hit_data);
      end else begin
        check("hit_data", hit_data, exp_hit_q.pop_front());
      end
    end
  end

  task automatic fetch_miss(input logic [31:0] addr);
    logic [31:0] base;
    base = addr & ~32'hF;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(4 * i));
    fetch_enable = 1'b1; pc = addr;
    tick;
    fetch_enable = 1'b0;
    check("miss_mem_enable", {31'b0, mem_enable}, 32'd1);
    check("miss_first_addr", inst_addr, base);
  endtask

  task automatic fetch_hit(input logic [31:0] addr);
    exp_hit_q.push_back(mem_word(addr));
    fetch_enable = 1'b1; pc = addr;
    tick;
    fetch_enable = 1'b0;
  endtask

  task automatic wait_fill;
    int n = 0;
    while (mem_enable && n < 64) begin
      tick;
      n++;
    end
    check("fill_done", {31'b0, mem_enable}, 32'd0);
  endtask

  task automatic beat(input logic inv);
    mem_valid = 1'b1; inst = mem_word(inst_addr); invalidate = inv;
    tick;
    mem_valid = 1'b0; invalidate = 1'b0;
  endtask

  task automatic drained(input string name);
    tick; tick;
    check({name, "_addr_q"}, 32'(exp_addr_q.size()), 32'd0);
    check({name, "_hit_q"}, 32'(exp_hit_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; fetch_enable = 1'b0; pc = '0;
    invalidate = 1'b0; mem_valid = 1'b0; inst = '0;
    repeat (3) tick;
    check("reset_hit", {31'b0, hit}, 32'd0);
    check("reset_hit_data", hit_data, 32'd0);
    check("reset_mem_enable", {31'b0, mem_enable}, 32'd0);
    check("reset_inst_addr", inst_addr, 32'd0);
    rst = 1'b0;
    auto_resp = 1'b1;

    // Basic refill and hit on the third word; hit_data holds after hit drops
    fetch_miss(32'h100);
    wait_fill;
    fetch_hit(32'h108);
    tick;
    check("hit_clears", {31'b0, hit}, 32'd0);
    check("hit_data_hold", hit_data, mem_word(32'h108));
    drained("t1");

    // Conflict on index 0x10 with a different tag evicts the line
    fetch_miss(32'h2100);
    wait_fill;
    fetch_hit(32'h2104);
    fetch_miss(32'h100);
    wait_fill;
    fetch_hit(32'h10C);
    drained("t2");

    // Fill runs to completion while pc changes and fetch drops; hits served during fill
    gappy = 1'b1;
    fetch_miss(32'h200);
    fetch_hit(32'h104);
    fetch_enable = 1'b1; pc = 32'h3000;
    tick;
    pc = 32'h3004;
    tick;
    fetch_enable = 1'b0;
    wait_fill;
    gappy = 1'b0;
    fetch_hit(32'h20C);
    fetch_hit(32'h200);
    fetch_hit(32'h100);
    drained("t3");

    // invalidate coinciding with the last returned word
    auto_resp = 1'b0;
    fetch_miss(32'h500);
    beat(1'b0); beat(1'b0); beat(1'b0); beat(1'b1);
    check("inv_last_mem_enable", {31'b0, mem_enable}, 32'd0);
    check("inv_last_addr_wrap", inst_addr, 32'h500);
    auto_resp = 1'b1;
    fetch_miss(32'h500);
    wait_fill;
    fetch_miss(32'h100);
    wait_fill;
    fetch_hit(32'h504);
    drained("t4");

    // rdy low freezes everything mid-fill while mem_valid toggles
    auto_resp = 1'b0;
    fetch_miss(32'h600);
    beat(1'b0); beat(1'b0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_valid = (i % 2 == 0); inst = 32'hDEAD_BEEF;
      fetch_enable = 1'b1; pc = 32'h100;
      tick;
      check("freeze_inst_addr", inst_addr, 32'h608);
      check("freeze_mem_enable", {31'b0, mem_enable}, 32'd1);
      check("freeze_hit", {31'b0, hit}, 32'd0);
    end
    rdy = 1'b1; fetch_enable = 1'b0; mem_valid = 1'b0;
    beat(1'b0); beat(1'b0);
    check("resume_done", {31'b0, mem_enable}, 32'd0);
    auto_resp = 1'b1;
    fetch_hit(32'h608);
    fetch_hit(32'h600);
    fetch_hit(32'h60C);
    drained("t5");

    // One miss followed by five hits
`ifdef ICACHE_PERF_EN
    ph0 = perf_hits; pm0 = perf_misses;
`endif
    fetch_miss(32'h700);
    wait_fill;
    for (int i = 0; i < 5; i++) fetch_hit(32'h700 + 32'(4 * (i % 4)));
    tick;
`ifdef ICACHE_PERF_EN
    check("perf_misses_delta", perf_misses - pm0, 32'd1);
    check("perf_hits_delta", perf_hits - ph0, 32'd5);
`endif
    drained("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
